seg7_count_monitor: RTL and testbench
=====================================

Name: seg7_count_monitor

Overview:
- Receiving end of the up/down counter's 7-segment display bus.
- Samples the `hex_out` pattern and filters transients.
- Decodes the pattern back to a 4-bit count value.
- Infers count direction and pause, and flags illegal patterns and skipped steps.
- Sits beside the counter as an in-system checker; also reused as a bench scoreboard front-end.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is accepted; legal range 1..15.
- PAUSE_CYCLES, 64: cycles without an accepted change before `paused` asserts; legal range 2..65535.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset (asserted at 0).
- seg_in, in, 7: segment pattern {g,f,e,d,c,b,a}, common-anode (segment lit = 0). Asynchronous to clk.
- clr_err, in, 1: synchronous clear of `err_count`.
- value_out, out, 4: last accepted legal value.
- value_valid, out, 1: one-cycle pulse when `value_out` updates.
- dir_up, out, 1: last legal step was +1 (mod 16).
- dir_down, out, 1: last legal step was -1 (mod 16).
- paused, out, 1: no accepted change for PAUSE_CYCLES cycles.
- step_err, out, 1: one-cycle pulse; accepted value is not ±1 from the previous value.
- illegal_err, out, 1: one-cycle pulse; a stable pattern is not in the decode table.
- err_count, out, ERR_W: saturating count of `step_err` plus `illegal_err` events.

Behaviour:
- Reset (reset=0, async):
  - value_out=0, value_valid=0, dir_up=0, dir_down=0, paused=0, step_err=0, illegal_err=0, err_count=0.
  - Sync flops and stability/pause counters go to 0; state goes to SYNC.
  - Reset asserted mid-operation aborts everything immediately.
- Input path: two-flop synchronizer gives s2. A stability counter increments while s2 equals its previous-cycle value and clears on any difference.
- Acceptance:
  - A pattern is accepted when it has been stable for STABLE_CYCLES samples and differs from the last accepted pattern.
  - Acceptance happens at most once per distinct pattern.
  - Latency: STABLE_CYCLES+2 rising edges from the first edge that samples the new pattern to `value_valid` high.
  - Transients shorter than STABLE_CYCLES are ignored silently.
- Decode table (pattern -> value):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3
  - 0011001->4, 0010010->5, 0000010->6, 1111000->7
  - 0000000->8, 0010000->9, 0001000->A, 0000011->b
  - 1000110->C, 0100001->d, 0000110->E, 0001110->F
  - All other 112 patterns are illegal.
- State machine, SYNC:
  - Legal accept: value_out<=v, value_valid pulse, no direction or step check, go to RUN.
  - Illegal accept: illegal_err pulse, stay in SYNC.
- State machine, RUN:
  - Legal accept of v with prev p, v==p+1 mod 16 (F->0 included): dir_up=1, dir_down=0.
  - Legal accept, v==p-1 mod 16 (0->F included): dir_down=1, dir_up=0.
  - Legal accept, otherwise: step_err pulse, dir bits unchanged, value still accepted (value_out<=v, value_valid pulse).
  - Illegal accept: illegal_err pulse, value_out holds, dir bits cleared, go to SYNC.
- Pause:
  - In RUN, a cycle counter clears on each accept and saturates.
  - `paused` goes high on the cycle the counter reaches PAUSE_CYCLES and clears in the same cycle as the next `value_valid`.
  - `paused` is forced to 0 in SYNC.
- err_count:
  - +1 per `step_err` or `illegal_err` pulse; saturates at all-ones.
  - clr_err=1 gives 0 on the next edge, overriding a simultaneous error.
- `step_err` and `illegal_err` are mutually exclusive; at most one accept per cycle.

Decomposition:
- Shared package/include `seg7_pkg`:
  - 16 pattern constants SEG_0..SEG_F, using the same encoding the counter's encoder uses.
  - State encodings ST_SYNC and ST_RUN.
  - Segment bit-order definition.
- One natural sub-module, `seg7_decode`: combinational pattern -> {legal, value[3:0]}. It is shared with future display-side checkers.

Test Plan:
- Reset, then hold seg_in=1000000 (0): value_valid after 6 edges, value_out=0, dir bits 0, err_count=0.
- Step 0->1->2->3, each held 10 cycles: three value_valid pulses; dir_up=1 from the first step; no errors.
- Wrap-around: step E->F->0, then 0->F: dir_up=1 through F->0; dir_down=1 after 0->F; step_err never fires.
- Glitch immunity, with value 5 accepted:
  - 2-cycle glitch to 0000000: no value_valid, value_out stays 5.
  - Skip 5->7 held stable: step_err pulse, value_out=7, err_count=1.
- Illegal and pause:
  - Pattern 1111111 held: illegal_err, state SYNC.
  - Then 3: accepted without step_err.
  - Then hold 3 for 64 cycles: paused=1; next change clears it.
- Saturation and clear:
  - With ERR_W=2, force 5 step errors: err_count=3.
  - clr_err together with an error: err_count=0.
  - Reset pulled low mid-count: all outputs 0 asynchronously.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display bus: segment bit order,
// the sixteen hex glyphs (common-anode, lit = 0) and monitor state encodings.
package seg7_pkg;

  localparam int SEG_W = 7;

  // Bit positions inside a pattern {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // Glyphs exactly as the counter's encoder drives them
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A_GLYPH = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B_GLYPH = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C_GLYPH = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D_GLYPH = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E_GLYPH = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F_GLYPH = 7'b0001110;

  // SYNC: no trusted reference value yet; RUN: stepping is being checked
  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex value decoder with legality flag.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic             legal_o,
  output logic [3:0]       value_o
);

  // Table lookup; anything that is not one of the sixteen glyphs is illegal
  always_comb begin
    legal_o = 1'b1;
    value_o = 4'h0;
    case (seg_i)
      SEG_0:       value_o = 4'h0;
      SEG_1:       value_o = 4'h1;
      SEG_2:       value_o = 4'h2;
      SEG_3:       value_o = 4'h3;
      SEG_4:       value_o = 4'h4;
      SEG_5:       value_o = 4'h5;
      SEG_6:       value_o = 4'h6;
      SEG_7:       value_o = 4'h7;
      SEG_8:       value_o = 4'h8;
      SEG_9:       value_o = 4'h9;
      SEG_A_GLYPH: value_o = 4'hA;
      SEG_B_GLYPH: value_o = 4'hB;
      SEG_C_GLYPH: value_o = 4'hC;
      SEG_D_GLYPH: value_o = 4'hD;
      SEG_E_GLYPH: value_o = 4'hE;
      SEG_F_GLYPH: value_o = 4'hF;
      default:     legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_count_monitor.sv
// In-system checker for an up/down counter's 7-segment bus: synchronizes and
// debounces the pattern, decodes it, tracks direction/pause, flags errors.
module seg7_count_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int PAUSE_CYCLES  = 64,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             clr_err,
  output logic [3:0]       value_out,
  output logic             value_valid,
  output logic             dir_up,
  output logic             dir_down,
  output logic             paused,
  output logic             step_err,
  output logic             illegal_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0]  STABLE_TH   = STABLE_CYCLES[3:0];
  localparam logic [15:0] PAUSE_TH    = PAUSE_CYCLES[15:0];
  localparam logic [15:0] PAUSE_TH_M1 = PAUSE_TH - 16'd1;
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [SEG_W-1:0] s1_q, s2_q;
  logic [3:0]       stab_q, stab_d;
  logic [SEG_W-1:0] acc_pat_q, acc_pat_d;
  logic             acc_vld_q, acc_vld_d;
  state_e           state_q, state_d;
  logic [3:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             up_q, up_d, down_q, down_d;
  logic [15:0]      pause_cnt_q, pause_cnt_d;
  logic             paused_q, paused_d;
  logic             step_q, step_d, ill_q, ill_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             dec_legal;
  logic [3:0]       dec_value;
  logic             accept;

  seg7_decode u_decode (
    .seg_i   (s2_q),
    .legal_o (dec_legal),
    .value_o (dec_value)
  );

  // stab_q = number of consecutive cycles s2 has held its current pattern
  always_comb begin
    stab_d = 4'd1;
    if (s1_q == s2_q) stab_d = (stab_q == 4'hF) ? stab_q : stab_q + 4'd1;
  end

  // A new stable pattern is taken exactly once
  assign accept = (stab_q >= STABLE_TH) && (!acc_vld_q || (s2_q != acc_pat_q));

  // Next-state, direction, pause and error bookkeeping
  always_comb begin
    state_d     = state_q;
    acc_pat_d   = acc_pat_q;
    acc_vld_d   = acc_vld_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    up_d        = up_q;
    down_d      = down_q;
    pause_cnt_d = pause_cnt_q;
    paused_d    = paused_q;
    step_d      = 1'b0;
    ill_d       = 1'b0;
    if (accept) begin
      acc_pat_d   = s2_q;
      acc_vld_d   = 1'b1;
      pause_cnt_d = 16'd0;
      if (dec_legal) begin
        value_d  = dec_value;
        valid_d  = 1'b1;
        paused_d = 1'b0;
        state_d  = ST_RUN;
        if (state_q == ST_RUN) begin
          if (dec_value == value_q + 4'd1) begin
            up_d   = 1'b1;
            down_d = 1'b0;
          end else if (dec_value == value_q - 4'd1) begin
            up_d   = 1'b0;
            down_d = 1'b1;
          end else begin
            step_d = 1'b1;
          end
        end
      end else begin
        ill_d    = 1'b1;
        up_d     = 1'b0;
        down_d   = 1'b0;
        paused_d = 1'b0;
        state_d  = ST_SYNC;
      end
    end else if (state_q == ST_RUN) begin
      if (pause_cnt_q != PAUSE_TH) pause_cnt_d = pause_cnt_q + 16'd1;
      if (pause_cnt_q >= PAUSE_TH_M1) paused_d = 1'b1;
    end else begin
      pause_cnt_d = 16'd0;
      paused_d    = 1'b0;
    end
    err_d = err_q;
    if (clr_err) err_d = '0;
    else if ((step_d || ill_d) && (err_q != '1)) err_d = err_q + ERR_ONE;
  end

  // State and output registers; reset clears everything at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      stab_q      <= '0;
      acc_pat_q   <= '0;
      acc_vld_q   <= 1'b0;
      state_q     <= ST_SYNC;
      value_q     <= '0;
      valid_q     <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      pause_cnt_q <= '0;
      paused_q    <= 1'b0;
      step_q      <= 1'b0;
      ill_q       <= 1'b0;
      err_q       <= '0;
    end else begin
      s1_q        <= seg_in;
      s2_q        <= s1_q;
      stab_q      <= stab_d;
      acc_pat_q   <= acc_pat_d;
      acc_vld_q   <= acc_vld_d;
      state_q     <= state_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      up_q        <= up_d;
      down_q      <= down_d;
      pause_cnt_q <= pause_cnt_d;
      paused_q    <= paused_d;
      step_q      <= step_d;
      ill_q       <= ill_d;
      err_q       <= err_d;
    end
  end

  assign value_out   = value_q;
  assign value_valid = valid_q;
  assign dir_up      = up_q;
  assign dir_down    = down_q;
  assign paused      = paused_q;
  assign step_err    = step_q;
  assign illegal_err = ill_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_seg7_count_monitor.sv
// Directed bench for seg7_count_monitor; a second instance with a 2-bit
// error counter shares the stimulus to exercise saturation.
module tb_seg7_count_monitor;

  localparam logic [6:0] SEG_TAB [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] seg_in = 7'b1000000;
  logic       clr_err = 1'b0;
  logic [3:0] value_out;
  logic       value_valid, dir_up, dir_down, paused, step_err, illegal_err;
  logic [7:0] err_count;
  logic [3:0] w2_value_out;
  logic       w2_value_valid, w2_dir_up, w2_dir_down, w2_paused, w2_step_err, w2_illegal_err;
  logic [1:0] w2_err_count;

  int checks = 0;
  int errors = 0;
  int valid_cnt, step_cnt, ill_cnt, first_valid, first_paused, first_unpaused;
  int tot_valid, tot_step;

  always #5 clk = ~clk;

  seg7_count_monitor #(.STABLE_CYCLES(4), .PAUSE_CYCLES(64), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clr_err(clr_err),
    .value_out(value_out), .value_valid(value_valid), .dir_up(dir_up),
    .dir_down(dir_down), .paused(paused), .step_err(step_err),
    .illegal_err(illegal_err), .err_count(err_count)
  );

  seg7_count_monitor #(.STABLE_CYCLES(4), .PAUSE_CYCLES(64), .ERR_W(2)) dut_w2 (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clr_err(clr_err),
    .value_out(w2_value_out), .value_valid(w2_value_valid), .dir_up(w2_dir_up),
    .dir_down(w2_dir_down), .paused(w2_paused), .step_err(w2_step_err),
    .illegal_err(w2_illegal_err), .err_count(w2_err_count)
  );

  // Drive a pattern for n cycles, recording pulses seen at each negedge
  task automatic apply(input logic [6:0] pat, input int n);
    seg_in = pat;
    valid_cnt = 0; step_cnt = 0; ill_cnt = 0;
    first_valid = 0; first_paused = 0; first_unpaused = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (value_valid) begin valid_cnt++; if (first_valid == 0) first_valid = i; end
      if (step_err) step_cnt++;
      if (illegal_err) ill_cnt++;
      if (paused && first_paused == 0) first_paused = i;
      if (!paused && first_unpaused == 0) first_unpaused = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (value_out !== 4'd0) begin errors++; $display("FAIL reset_value: got %0d expected 0", value_out); end
    checks++; if ({value_valid, dir_up, dir_down, paused, step_err, illegal_err} !== 6'b0) begin errors++; $display("FAIL reset_flags: got %b expected 000000", {value_valid, dir_up, dir_down, paused, step_err, illegal_err}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_first_accept();
    apply(SEG_TAB[0], 10);
    checks++; if (first_valid !== 6) begin errors++; $display("FAIL first_latency: got %0d expected 6", first_valid); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL first_pulses: got %0d expected 1", valid_cnt); end
    checks++; if (value_out !== 4'd0) begin errors++; $display("FAIL first_value: got %0d expected 0", value_out); end
    checks++; if ({dir_up, dir_down} !== 2'b00) begin errors++; $display("FAIL first_dir: got %b expected 00", {dir_up, dir_down}); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL first_err: got %0d expected 0", err_count); end
    $display("test_first_accept done");
  endtask

  task automatic test_count_up();
    tot_valid = 0; tot_step = 0;
    apply(SEG_TAB[1], 10); tot_valid += valid_cnt; tot_step += step_cnt;
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL up_first_dir: got %b expected 1", dir_up); end
    apply(SEG_TAB[2], 10); tot_valid += valid_cnt; tot_step += step_cnt;
    apply(SEG_TAB[3], 10); tot_valid += valid_cnt; tot_step += step_cnt;
    checks++; if (tot_valid !== 3) begin errors++; $display("FAIL up_pulses: got %0d expected 3", tot_valid); end
    checks++; if (tot_step !== 0) begin errors++; $display("FAIL up_steperr: got %0d expected 0", tot_step); end
    checks++; if (value_out !== 4'd3) begin errors++; $display("FAIL up_value: got %0d expected 3", value_out); end
    $display("test_count_up done");
  endtask

  task automatic test_wrap();
    tot_step = 0;
    for (int v = 4; v <= 15; v++) begin apply(SEG_TAB[v], 10); tot_step += step_cnt; end
    apply(SEG_TAB[0], 10); tot_step += step_cnt;
    checks++; if ({dir_up, dir_down} !== 2'b10) begin errors++; $display("FAIL wrap_up_dir: got %b expected 10", {dir_up, dir_down}); end
    checks++; if (value_out !== 4'd0) begin errors++; $display("FAIL wrap_up_value: got %0d expected 0", value_out); end
    apply(SEG_TAB[15], 10); tot_step += step_cnt;
    checks++; if ({dir_up, dir_down} !== 2'b01) begin errors++; $display("FAIL wrap_down_dir: got %b expected 01", {dir_up, dir_down}); end
    checks++; if (value_out !== 4'd15) begin errors++; $display("FAIL wrap_down_value: got %0d expected 15", value_out); end
    for (int v = 0; v <= 5; v++) begin apply(SEG_TAB[v], 10); tot_step += step_cnt; end
    checks++; if (tot_step !== 0) begin errors++; $display("FAIL wrap_steperr: got %0d expected 0", tot_step); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL wrap_err: got %0d expected 0", err_count); end
    $display("test_wrap done");
  endtask

  task automatic test_glitch();
    apply(SEG_TAB[8], 2); tot_valid = valid_cnt;
    apply(SEG_TAB[5], 10); tot_valid += valid_cnt;
    checks++; if (tot_valid !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", tot_valid); end
    checks++; if (value_out !== 4'd5) begin errors++; $display("FAIL glitch_value: got %0d expected 5", value_out); end
    apply(SEG_TAB[7], 10);
    checks++; if (step_cnt !== 1) begin errors++; $display("FAIL skip_steperr: got %0d expected 1", step_cnt); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL skip_pulses: got %0d expected 1", valid_cnt); end
    checks++; if (value_out !== 4'd7) begin errors++; $display("FAIL skip_value: got %0d expected 7", value_out); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL skip_err: got %0d expected 1", err_count); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL skip_dir_hold: got %b expected 1", dir_up); end
    $display("test_glitch done");
  endtask

  task automatic test_illegal_pause();
    apply(7'b1111111, 10);
    checks++; if (ill_cnt !== 1) begin errors++; $display("FAIL illegal_pulses: got %0d expected 1", ill_cnt); end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL illegal_valid: got %0d expected 0", valid_cnt); end
    checks++; if (value_out !== 4'd7) begin errors++; $display("FAIL illegal_value: got %0d expected 7", value_out); end
    checks++; if ({dir_up, dir_down} !== 2'b00) begin errors++; $display("FAIL illegal_dir: got %b expected 00", {dir_up, dir_down}); end
    checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL illegal_err: got %0d expected 2", err_count); end
    apply(SEG_TAB[3], 75);
    checks++; if (first_valid !== 6) begin errors++; $display("FAIL resync_latency: got %0d expected 6", first_valid); end
    checks++; if (step_cnt !== 0) begin errors++; $display("FAIL resync_steperr: got %0d expected 0", step_cnt); end
    checks++; if (value_out !== 4'd3) begin errors++; $display("FAIL resync_value: got %0d expected 3", value_out); end
    checks++; if (first_paused !== 70) begin errors++; $display("FAIL pause_edge: got %0d expected 70", first_paused); end
    apply(SEG_TAB[4], 10);
    checks++; if (first_valid !== 6) begin errors++; $display("FAIL unpause_valid: got %0d expected 6", first_valid); end
    checks++; if (first_unpaused !== 6) begin errors++; $display("FAIL unpause_edge: got %0d expected 6", first_unpaused); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL unpause_dir: got %b expected 1", dir_up); end
    $display("test_illegal_pause done");
  endtask

  task automatic test_saturation();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_err8: got %0d expected 0", err_count); end
    checks++; if (w2_err_count !== 2'd0) begin errors++; $display("FAIL clr_err2: got %0d expected 0", w2_err_count); end
    tot_step = 0;
    for (int v = 6; v <= 14; v += 2) begin apply(SEG_TAB[v], 10); tot_step += step_cnt; end
    checks++; if (tot_step !== 5) begin errors++; $display("FAIL sat_steps: got %0d expected 5", tot_step); end
    checks++; if (err_count !== 8'd5) begin errors++; $display("FAIL sat_err8: got %0d expected 5", err_count); end
    checks++; if (w2_err_count !== 2'd3) begin errors++; $display("FAIL sat_err2: got %0d expected 3", w2_err_count); end
    $display("test_saturation done");
  endtask

  task automatic test_clr_collision();
    seg_in = SEG_TAB[1];
    repeat (5) @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++; if (step_err !== 1'b1) begin errors++; $display("FAIL coll_steperr: got %b expected 1", step_err); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL coll_err8: got %0d expected 0", err_count); end
    checks++; if (w2_err_count !== 2'd0) begin errors++; $display("FAIL coll_err2: got %0d expected 0", w2_err_count); end
    repeat (4) @(negedge clk);
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL coll_after: got %0d expected 0", err_count); end
    $display("test_clr_collision done");
  endtask

  task automatic test_async_reset();
    apply(SEG_TAB[3], 10);
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL pre_reset_err: got %0d expected 1", err_count); end
    checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL pre_reset_dir: got %b expected 1", dir_up); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (value_out !== 4'd0) begin errors++; $display("FAIL async_value: got %0d expected 0", value_out); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL async_err: got %0d expected 0", err_count); end
    checks++; if ({value_valid, dir_up, dir_down, paused, step_err, illegal_err} !== 6'b0) begin errors++; $display("FAIL async_flags: got %b expected 000000", {value_valid, dir_up, dir_down, paused, step_err, illegal_err}); end
    @(negedge clk);
    reset = 1'b1;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_first_accept();
    test_count_up();
    test_wrap();
    test_glitch();
    test_illegal_pause();
    test_saturation();
    test_clr_collision();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
